// File: rtl/mean_level_monitor.sv
// ============================================================================
// Module   : mean_level_monitor
// Brief    : Hysteresis/debounce level alarm on a stream of mean samples, with
//            rise/fall pulses and a saturating alarm-episode counter.
//            Optional peak tracking enabled by LEVEL_MONITOR_PEAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mean_level_monitor #(
  parameter int WIDTH     = 8,
  parameter int DEBOUNCE  = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 mean_valid,
  input  logic [WIDTH-1:0]     mean_in,
  input  logic [WIDTH-1:0]     thr_hi,
  input  logic [WIDTH-1:0]     thr_lo,
  input  logic                 clear,
  output logic                 alarm,
  output logic                 alarm_rise,
  output logic                 alarm_fall,
  output logic [CNT_WIDTH-1:0] event_count
`ifdef LEVEL_MONITOR_PEAK_EN
  ,output logic [WIDTH-1:0]    peak_out
`endif
);

  localparam int            CW    = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_PEND_HI = 2'd1,
    S_ALARM   = 2'd2,
    S_PEND_LO = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 alarm_q, alarm_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic          above, below;
  logic [CW-1:0] cnt_inc;

  assign above   = mean_in > thr_hi;
  assign below   = mean_in < thr_lo;
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    if (clear) begin
      state_d = S_NORMAL;
      cnt_d   = '0;
      count_d = '0;
    end else if (mean_valid) begin
      case (state_q)
        S_NORMAL: if (above) begin
          if (DEBOUNCE == 1) begin
            state_d = S_ALARM;
            rise_d  = 1'b1;
          end else begin
            state_d = S_PEND_HI;
            cnt_d   = ONE_C;
          end
        end
        S_PEND_HI: begin
          if (!above) begin
            state_d = S_NORMAL;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_d = S_ALARM;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ALARM: if (below) begin
          if (DEBOUNCE == 1) begin
            state_d = S_NORMAL;
            fall_d  = 1'b1;
          end else begin
            state_d = S_PEND_LO;
            cnt_d   = ONE_C;
          end
        end
        S_PEND_LO: begin
          if (!below) begin
            state_d = S_ALARM;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_d = S_NORMAL;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_NORMAL;
          cnt_d   = '0;
        end
      endcase
      // Saturate instead of wrapping so a stuck-high count stays visible.
      if (rise_d && (count_q != {CNT_WIDTH{1'b1}})) begin
        count_d = count_q + 1'b1;
      end
    end
    alarm_d = (state_d == S_ALARM) || (state_d == S_PEND_LO);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_NORMAL;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_rise  = rise_q;
  assign alarm_fall  = fall_q;
  assign event_count = count_q;

`ifdef LEVEL_MONITOR_PEAK_EN
  // run_q tracks the max of the pending entry run; peak_q only changes on
  // entry or while alarmed, so it holds its last value after exit.
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0] run_q, run_d;
  logic [WIDTH-1:0] run_max;

  assign run_max = (mean_in > run_q) ? mean_in : run_q;

  always_comb begin
    peak_d = peak_q;
    run_d  = run_q;
    if (clear) begin
      peak_d = '0;
      run_d  = '0;
    end else if (mean_valid) begin
      case (state_q)
        S_NORMAL:  if (above) run_d = mean_in;
        S_PEND_HI: if (above) run_d = run_max;
        default:   if (mean_in > peak_q) peak_d = mean_in;
      endcase
      if (rise_d) begin
        peak_d = (state_q == S_NORMAL) ? mean_in : run_max;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      peak_q <= '0;
      run_q  <= '0;
    end else begin
      peak_q <= peak_d;
      run_q  <= run_d;
    end
  end

  assign peak_out = peak_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mean_level_monitor.sv
// ============================================================================
// Module   : tb_mean_level_monitor
// Brief    : Directed self-checking bench for mean_level_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mean_level_monitor;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] thr_hi = 8'd100;
  logic [7:0] thr_lo = 8'd80;

  logic       v1 = 1'b0, clr1 = 1'b0;
  logic [7:0] m1 = 8'd0;
  logic       alarm1, rise1, fall1;
  logic [7:0] cnt1;

  logic       v2 = 1'b0, clr2 = 1'b0;
  logic [7:0] m2 = 8'd0;
  logic       alarm2, rise2, fall2;
  logic [1:0] cnt2;

`ifdef LEVEL_MONITOR_PEAK_EN
  logic [7:0] peak1, peak2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mean_level_monitor #(.WIDTH(8), .DEBOUNCE(3), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .arst_n(arst_n), .mean_valid(v1), .mean_in(m1),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clr1),
    .alarm(alarm1), .alarm_rise(rise1), .alarm_fall(fall1), .event_count(cnt1)
`ifdef LEVEL_MONITOR_PEAK_EN
    ,.peak_out(peak1)
`endif
  );

  mean_level_monitor #(.WIDTH(8), .DEBOUNCE(1), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .arst_n(arst_n), .mean_valid(v2), .mean_in(m2),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clr2),
    .alarm(alarm2), .alarm_rise(rise2), .alarm_fall(fall2), .event_count(cnt2)
`ifdef LEVEL_MONITOR_PEAK_EN
    ,.peak_out(peak2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given input on DUT1; outputs sampled 1ns after the edge.
  task automatic s1(input logic v, input logic [7:0] m);
    v1 = v; m1 = m;
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic s2(input logic v, input logic [7:0] m, input logic c);
    v2 = v; m2 = m; clr2 = c;
    @(posedge clk); #1;
    v2 = 1'b0; clr2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with an aggressive input present
    v1 = 1'b1; m1 = 8'd255; v2 = 1'b1; m2 = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alarm", alarm1, 0);
    check("rst_rise", rise1, 0);
    check("rst_fall", fall1, 0);
    check("rst_count", cnt1, 0);
    check("rst_alarm2", alarm2, 0);
`ifdef LEVEL_MONITOR_PEAK_EN
    check("rst_peak", peak1, 0);
`endif
    v1 = 1'b0; v2 = 1'b0;
    #3 arst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_alarm", alarm1, 0);

    // Samples equal to thr_hi never count
    repeat (3) s1(1, 8'd100);
    check("eq_thr_no_alarm", alarm1, 0);

    // Entry after three strict-above samples
    s1(1, 8'd101);
    s1(1, 8'd101);
    check("entry_pend2", alarm1, 0);
    s1(1, 8'd101);
    check("entry_alarm", alarm1, 1);
    check("entry_rise", rise1, 1);
    check("entry_count", cnt1, 1);
    s1(0, 8'd0);
    check("rise_one_cycle", rise1, 0);
    check("alarm_held", alarm1, 1);

    // Inside hysteresis band: no exit
    repeat (5) s1(1, 8'd90);
    check("band_hold", alarm1, 1);

    s1(1, 8'd79);
    s1(1, 8'd79);
    check("exit_pend_alarm", alarm1, 1);
    check("exit_pend_fall", fall1, 0);
    s1(1, 8'd79);
    check("exit_alarm", alarm1, 0);
    check("exit_fall", fall1, 1);
    s1(0, 8'd0);
    check("fall_one_cycle", fall1, 0);

    // Debounce restart on a non-qualifying sample
    s1(1, 8'd101); s1(1, 8'd101); s1(1, 8'd99); s1(1, 8'd101); s1(1, 8'd101);
    check("restart_no_alarm", alarm1, 0);
    s1(1, 8'd99);

    // Count held across idle gaps
    s1(1, 8'd101);
    repeat (4) s1(0, 8'd200);
    s1(1, 8'd101);
    check("gap_pend", alarm1, 0);
    s1(1, 8'd101);
    check("gap_alarm", alarm1, 1);
    check("gap_count", cnt1, 2);

    // Interrupted exit run returns to ALARM
    s1(1, 8'd79); s1(1, 8'd101); s1(1, 8'd79);
    check("no_exit_interrupt", alarm1, 1);
    s1(1, 8'd79);
    check("pend_lo_cnt2", alarm1, 1);
    s1(1, 8'd79);
    check("exit2_alarm", alarm1, 0);
    check("exit2_fall", fall1, 1);

`ifdef LEVEL_MONITOR_PEAK_EN
    s1(1, 8'd120);
    check("peak_hold_pend", peak1, 101);
    s1(1, 8'd110);
    s1(1, 8'd130);
    check("peak_entry", peak1, 130);
    check("peak_entry_alarm", alarm1, 1);
    s1(1, 8'd140);
    check("peak_update", peak1, 140);
    s1(1, 8'd125);
    check("peak_no_lower", peak1, 140);
    repeat (3) s1(1, 8'd79);
    check("peak_exit_alarm", alarm1, 0);
    s1(0, 8'd0);
    check("peak_after_exit", peak1, 140);

    // Async reset in the middle of a pending run
    s1(1, 8'd120);
    #4 arst_n = 1'b0;
    #1;
    check("async_peak", peak1, 0);
    check("async_count", cnt1, 0);
    #2 arst_n = 1'b1;
    s1(1, 8'd120);
    s1(1, 8'd120);
    check("post_rst_pend", alarm1, 0);
    s1(1, 8'd120);
    check("post_rst_entry", alarm1, 1);
    check("post_rst_count", cnt1, 1);
    check("post_rst_peak", peak1, 120);
`endif

    // DEBOUNCE=1, CNT_WIDTH=2: saturation
    for (int i = 1; i <= 4; i++) begin
      s2(1, 8'd101, 0);
      check("sat_alarm", alarm2, 1);
      check("sat_rise", rise2, 1);
      check("sat_count", cnt2, (i > 3) ? 3 : i);
      s2(1, 8'd79, 0);
      check("sat_exit", alarm2, 0);
      check("sat_fall", fall2, 1);
    end

    // clear beats a simultaneous valid entry sample
    s2(1, 8'd101, 1);
    check("clr_alarm", alarm2, 0);
    check("clr_count", cnt2, 0);
    check("clr_rise", rise2, 0);
    s2(1, 8'd101, 0);
    check("clr_reentry_count", cnt2, 1);
    s2(1, 8'd79, 1);
    check("clr_in_alarm", alarm2, 0);
    check("clr_no_fall", fall2, 0);
    check("clr_count2", cnt2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mean_level_monitor.md
Name: mean_level_monitor

Overview:
Downstream consumer of the moving-average mean stage. Watches each new mean sample against runtime high/low thresholds with hysteresis and a consecutive-sample debounce. Raises a level alarm with one-cycle rise/fall event pulses, and keeps a saturating count of alarm episodes for status readout.

Parameters:
WIDTH, 8, bit width of mean_in, thr_hi, thr_lo.
DEBOUNCE, 3, number of consecutive qualifying valid samples needed to enter or leave alarm; legal range is 1 or greater.
CNT_WIDTH, 8, width of event_count.

Ports:
clk  in  1  clock, rising edge.
arst_n  in  1  asynchronous active-low reset.
mean_valid  in  1  strobe; mean_in is a new sample this cycle.
mean_in  in  WIDTH  unsigned mean sample.
thr_hi  in  WIDTH  unsigned alarm-entry threshold; sampled on every valid.
thr_lo  in  WIDTH  unsigned alarm-exit threshold; sampled on every valid.
clear  in  1  synchronous soft clear.
alarm  out  1  level alarm.
alarm_rise  out  1  one-cycle pulse on alarm entry.
alarm_fall  out  1  one-cycle pulse on alarm exit.
event_count  out  CNT_WIDTH  number of alarm entries, saturating.

Behaviour:
- Reset is arst_n, asynchronous, active-low; clock is clk. Reset forces: state NORMAL, debounce cnt 0, alarm 0, alarm_rise 0, alarm_fall 0, event_count 0.
- Only cycles with mean_valid=1 are evaluated. Cycles with mean_valid=0 hold state and cnt, and drive both pulses to 0.
- above = mean_in > thr_hi (strict). below = mean_in < thr_lo (strict). Both comparisons are unsigned.
- Debounce counter cnt has width clog2(DEBOUNCE+1).
- FSM states and transitions:
  - NORMAL: valid & above: if DEBOUNCE==1, go to ALARM; else cnt=1 and go to PEND_HI.
  - PEND_HI: valid & above: cnt+1; when cnt+1==DEBOUNCE, go to ALARM and clear cnt. valid & !above: cnt=0, back to NORMAL.
  - ALARM: valid & below: if DEBOUNCE==1, go to NORMAL; else cnt=1 and go to PEND_LO.
  - PEND_LO: valid & below: cnt+1; when cnt+1==DEBOUNCE, go to NORMAL and clear cnt. valid & !below: cnt=0, back to ALARM.
- All outputs are registered. alarm=1 in ALARM and PEND_LO, and updates the cycle after the completing valid sample.
- alarm_rise is high for exactly that one cycle on the PEND_HI/NORMAL to ALARM transition. alarm_fall is the mirror on entry to NORMAL from alarm.
- event_count increments with alarm_rise and saturates at 2^CNT_WIDTH-1; it never wraps.
- clear (synchronous, priority over mean_valid): next cycle state NORMAL, cnt 0, alarm 0, pulses 0, event_count 0. No alarm_fall is produced by clear.
- thr_lo > thr_hi is not rejected; the rules above apply unchanged. Only above is tested in NORMAL/PEND_HI, and only below in ALARM/PEND_LO.
- Threshold changes take effect on the next valid sample. In-progress cnt is not reset by a threshold change.

Optional Feature:
Macro LEVEL_MONITOR_PEAK_EN.
- Defined: adds output peak_out (WIDTH bits, reset 0).
  - On alarm entry, peak_out loads the maximum mean_in seen over the qualifying debounce run.
  - While in ALARM/PEND_LO, every valid sample with mean_in > peak_out updates it.
  - After exit, it holds its value until the next entry. clear zeroes it.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold arst_n=0 with mean_valid=1 and mean_in=255 -> alarm=0, pulses=0, event_count=0. Release mid-cycle -> still NORMAL.
2. Entry (DEBOUNCE=3, thr_hi=100, thr_lo=80): valid samples 101,101,101 -> alarm=1 one cycle after the third sample, alarm_rise high exactly 1 cycle, event_count=1. Samples of 100 (equal to thr_hi) never count.
3. Debounce restart and gaps: 101,101,99,101,101 -> alarm stays 0. Then 101, 4 idle cycles, 101, 101 -> alarm=1 (count held across gaps).
4. Hysteresis exit: in alarm, feed 90 x5 -> alarm stays 1. Then 79,79,79 -> alarm_fall pulse, alarm=0. Then 79,101,79 from ALARM -> no exit.
5. Saturation and clear: CNT_WIDTH=2, DEBOUNCE=1, four entry/exit episodes -> event_count=3. Assert clear in the same cycle as a valid 101 -> next cycle alarm=0, event_count=0, no alarm_rise.
6. Peak (macro defined): entry samples 120,110,130, then in alarm 140,125, then exit -> peak_out 130 at entry, 140 after, holds 140 after exit. Async reset mid-PEND_HI -> NORMAL, peak_out=0.
